// File: rtl/ssd_pkg.sv
// Shared types and constants for the two-digit Pmod SSD scan controller.
package ssd_pkg;

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } scan_state_t;

  localparam int DIGIT_CYCLES_DEF = 25_000;
  localparam int DEAD_CYCLES_DEF  = 500;

  localparam logic [1:0] ENTRY_MAX = 2'd2;

  function automatic logic [1:0] entry_inc(input logic [1:0] c);
    return (c >= ENTRY_MAX) ? ENTRY_MAX : c + 2'd1;
  endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// Slot counter and blank/drive FSM; toggles chip_sel only on entry to blank.
module ssd_scan_timer
  import ssd_pkg::*;
#(
  parameter int DIGIT_CYCLES = DIGIT_CYCLES_DEF,
  parameter int DEAD_CYCLES  = DEAD_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic chip_sel_o,
  output logic raw_blank_o
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (!en_i) begin
      // Frozen: restart the slot with a full dead-time on re-enable.
      state_d = S_BLANK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_BLANK: begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == DEAD_LAST) begin
            state_d = S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_d   = '0;
            sel_d   = ~sel_q;
            state_d = S_BLANK;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign chip_sel_o  = sel_q;
  assign raw_blank_o = (state_q == S_BLANK);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Two-digit key-entry buffer multiplexed onto the Pmod SSD with dead-time.
// Define SSD_LZ_BLANK_EN to blank unentered leading digits.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int DIGIT_CYCLES = DIGIT_CYCLES_DEF,
  parameter int DEAD_CYCLES  = DEAD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       clear,
  output logic [3:0] digit_val,
  output logic       chip_sel,
  output logic       blank,
  output logic [7:0] value,
  output logic [1:0] entry_cnt
);

  logic       raw_blank;
  logic       lz_blank;
  logic [7:0] value_q, value_d;
  logic [1:0] cnt_q, cnt_d;

  ssd_scan_timer #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .en_i       (scan_en),
    .chip_sel_o (chip_sel),
    .raw_blank_o(raw_blank)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear is applied first so a same-cycle key lands in an empty buffer.
  always_comb begin
    value_d = value_q;
    cnt_d   = cnt_q;
    if (clear) begin
      value_d = '0;
      cnt_d   = '0;
    end
    if (key_valid) begin
      value_d = {value_d[3:0], key_code};
      cnt_d   = entry_inc(cnt_d);
    end
  end

`ifdef SSD_LZ_BLANK_EN
  assign lz_blank = (cnt_q == 2'd0)
                  | (chip_sel & (cnt_q < ENTRY_MAX));
`else
  assign lz_blank = 1'b0;
`endif

  assign blank     = raw_blank | ~scan_en | lz_blank;
  assign digit_val = chip_sel ? value_q[7:4] : value_q[3:0];
  assign value     = value_q;
  assign entry_cnt = cnt_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with DIGIT_CYCLES=8, DEAD_CYCLES=2.
module tb_ssd_scan_ctrl;

  localparam int DC = 8;
  localparam int DD = 2;
`ifdef SSD_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_en = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       clear = 1'b0;
  logic [3:0] digit_val;
  logic       chip_sel;
  logic       blank;
  logic [7:0] value;
  logic [1:0] entry_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       clr;
    logic [7:0] exp_val;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .DIGIT_CYCLES(DC),
    .DEAD_CYCLES (DD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_en  (scan_en),
    .key_valid(key_valid),
    .key_code (key_code),
    .clear    (clear),
    .digit_val(digit_val),
    .chip_sel (chip_sel),
    .blank    (blank),
    .value    (value),
    .entry_cnt(entry_cnt)
  );

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    scan_en = 1'b1;
    key_valid = 1'b0;
    clear = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
  endtask

  initial begin
    bit seen0, seen1;

    vecs[0] = '{1'b1, 4'h5, 1'b0, 8'h05, 2'd1};
    vecs[1] = '{1'b1, 4'hA, 1'b0, 8'h5A, 2'd2};
    vecs[2] = '{1'b1, 4'h3, 1'b0, 8'hA3, 2'd2};
    vecs[3] = '{1'b0, 4'h0, 1'b1, 8'h00, 2'd0};
    vecs[4] = '{1'b1, 4'h5, 1'b0, 8'h05, 2'd1};
    vecs[5] = '{1'b1, 4'hA, 1'b0, 8'h5A, 2'd2};
    vecs[6] = '{1'b1, 4'h7, 1'b1, 8'h07, 2'd1};
    vecs[7] = '{1'b1, 4'h9, 1'b0, 8'h79, 2'd2};
    vecs[8] = '{1'b0, 4'h0, 1'b1, 8'h00, 2'd0};
    vecs[9] = '{1'b1, 4'hF, 1'b0, 8'h0F, 2'd1};

    // Reset state and idle scan timing
    rst = 1'b0;
    repeat (3) step();
    chk("rst_blank", 8'(blank), 8'h1);
    chk("rst_sel", 8'(chip_sel), 8'h0);
    chk("rst_value", value, 8'h00);
    chk("rst_cnt", 8'(entry_cnt), 8'h0);
    rst = 1'b1;
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("idle_blank_k%0d", k), 8'(blank),
          8'(((k % DC) < DD) || (LZ)));
      chk($sformatf("idle_sel_k%0d", k), 8'(chip_sel), 8'((k / DC) % 2));
      step();
    end

    // Entry buffer vectors, including same-cycle clear + key
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        // Digit mux check with buffer holding A3
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int c = 0; c < 3 * DC && !(seen0 && seen1); c++) begin
          if (!chip_sel && !seen0) begin
            chk("dv_ones", 8'(digit_val), 8'h03);
            seen0 = 1'b1;
          end else if (chip_sel && !seen1) begin
            chk("dv_tens", 8'(digit_val), 8'h0A);
            seen1 = 1'b1;
          end
          step();
        end
        chk("dv_seen_both", 8'({seen0, seen1}), 8'h3);
      end
      key_valid = vecs[i].kv;
      key_code  = vecs[i].kc;
      clear     = vecs[i].clr;
      step();
      key_valid = 1'b0;
      clear     = 1'b0;
      chk($sformatf("vec%0d_value", i), value, vecs[i].exp_val);
      chk($sformatf("vec%0d_cnt", i), 8'(entry_cnt), 8'(vecs[i].exp_cnt));
    end

    // Leading-digit handling with a single key 4
    do_reset();
    key_valid = 1'b1;
    key_code  = 4'h4;
    step();
    key_valid = 1'b0;
    for (int k = 1; k < 24; k++) begin
      chk($sformatf("lz_blank_k%0d", k), 8'(blank),
          8'(((k % DC) < DD) || (LZ && ((k / DC) % 2 == 1))));
      chk($sformatf("lz_dv_k%0d", k), 8'(digit_val),
          ((k / DC) % 2 == 1) ? 8'h00 : 8'h04);
      step();
    end

    // scan_en freeze at S_DRIVE counter=4
    do_reset();
    press(4'h1);
    press(4'h2);
    repeat (2) step();
    chk("frz_pre_blank", 8'(blank), 8'h0);
    scan_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("frz_blank_%0d", i), 8'(blank), 8'h1);
      chk($sformatf("frz_sel_%0d", i), 8'(chip_sel), 8'h0);
    end
    scan_en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("ren_blank_%0d", j), 8'(blank),
          8'(j < DD || j >= DC));
      chk($sformatf("ren_sel_%0d", j), 8'(chip_sel), 8'(j >= DC));
      step();
    end

    // Reset mid-drive with chip_sel=1 and buffer 5A
    do_reset();
    press(4'h5);
    press(4'hA);
    repeat (DC + 2) step();
    chk("r6_pre_sel", 8'(chip_sel), 8'h1);
    chk("r6_pre_blank", 8'(blank), 8'h0);
    chk("r6_pre_value", value, 8'h5A);
    rst = 1'b0;
    step();
    chk("r6_blank", 8'(blank), 8'h1);
    chk("r6_sel", 8'(chip_sel), 8'h0);
    chk("r6_value", value, 8'h00);
    chk("r6_cnt", 8'(entry_cnt), 8'h0);
    chk("r6_dv", 8'(digit_val), 8'h0);
    rst = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
